// File: rtl/chess_avmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chess_avmm_pkg
// Description : Shared constants and host state encoding for the chess
//               move-generator host master and its bus access engine.
// Revision    : 1.0 - initial release
// ============================================================================
package chess_avmm_pkg;

    // Control slave register map (word addresses)
    localparam int CTRL_ADDR   = 0;    // control / status word
    localparam int BOARD_BASE  = 2;    // first board row word

    // Control word bit that kicks off generation
    localparam int START_BIT   = 0;

    // Board geometry and the span cleared before every job
    localparam int BOARD_ROWS  = 8;
    localparam int CLEAR_WORDS = 10;   // addresses 0..9: control, spare, 8 rows

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLEAR  = 4'd1,
        ST_LOAD   = 4'd2,
        ST_CTRL   = 4'd3,
        ST_START  = 4'd4,
        ST_POLL   = 4'd5,
        ST_FETCH  = 4'd6,
        ST_EMIT   = 4'd7,
        ST_FINISH = 4'd8
    } host_state_t;

endpackage
`default_nettype wire

// File: rtl/avmm_single_access.sv
`default_nettype none
// ============================================================================
// Module      : avmm_single_access
// Description : Performs one Avalon-MM access at a time. A write holds the
//               write strobe for exactly one cycle; a read holds the read
//               strobe for READ_LATENCY+1 cycles and samples readdata on the
//               last one. Every access is followed by an idle cycle, during
//               which ack pulses and rdata is valid.
// Ports       : clk, reset           - clock, async active-high reset
//               req/we/addr/wdata    - access request (accepted when ready)
//               ready                - engine idle, request will be taken
//               ack/rdata            - completion pulse, captured read data
//               master_*             - Avalon-MM master strobes and data
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_single_access #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] master_address,
    output logic                  master_read,
    output logic                  master_write,
    output logic [DATA_WIDTH-1:0] master_writedata,
    input  logic [DATA_WIDTH-1:0] master_readdata
);

    localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]         cnt_q,   cnt_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = S_GAP;
            S_READ: begin
                // Slave data is only guaranteed on the final strobe cycle
                if (cnt_q == CNT_LAST) begin
                    rdata_d = master_readdata;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state flop so that reset drops the
    // strobes immediately without waiting for a clock edge.
    always_comb begin
        ready            = (state_q == S_IDLE);
        ack              = (state_q == S_GAP);
        rdata            = rdata_q;
        master_read      = (state_q == S_READ);
        master_write     = (state_q == S_WRITE);
        master_address   = addr_q;
        master_writedata = wdata_q;
    end

endmodule
`default_nettype wire

// File: rtl/chess_board_host_master.sv
`default_nettype none
// ============================================================================
// Module      : chess_board_host_master
// Description : Avalon-MM master sequencing the chess move-generator control
//               slave: clears and loads a board, starts generation, polls for
//               done, then reads each result word and streams it out on a
//               valid/ready interface.
// Ports       : clk, reset          - clock, async active-high reset
//               cmd_valid/ready     - job request handshake, cmd_board rows
//               master_*            - Avalon-MM master interface
//               res_valid/ready     - result stream (res_data, res_last)
//               busy                - job in progress
//               error               - sticky poll timeout flag
// Options     : CHESS_HOST_TIMEOUT_EN - when defined, give up after
//               POLL_LIMIT status polls, set error and skip the results.
// Revision    : 1.0 - initial release
// ============================================================================
module chess_board_host_master
    import chess_avmm_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 13,
    parameter int                    READ_LATENCY = 2,
    parameter int                    RESULT_BASE  = 16,
    parameter int                    RESULT_WORDS = 100,
    parameter logic [DATA_WIDTH-1:0] CTRL_MODE    = 32'h40,
    parameter int                    DONE_BIT     = 1,
    parameter int                    POLL_LIMIT   = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [8*DATA_WIDTH-1:0] cmd_board,
    output logic [ADDR_WIDTH-1:0]   master_address,
    output logic                    master_read,
    output logic                    master_write,
    output logic [DATA_WIDTH-1:0]   master_writedata,
    output logic [DATA_WIDTH/8-1:0] master_byteenable,
    input  logic [DATA_WIDTH-1:0]   master_readdata,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_last,
    output logic                    busy,
    output logic                    error
);

    localparam int KW = $clog2(RESULT_WORDS + 1);
    localparam logic [KW-1:0]         K_LAST     = KW'(RESULT_WORDS - 1);
    localparam logic [DATA_WIDTH-1:0] START_WORD = CTRL_MODE | (DATA_WIDTH'(1) << START_BIT);

    host_state_t                                state_q,    state_d;
    logic [BOARD_ROWS-1:0][DATA_WIDTH-1:0]      rows_q,     rows_d;
    logic [3:0]                                 idx_q,      idx_d;
    logic [KW-1:0]                              k_q,        k_d;
    logic [DATA_WIDTH-1:0]                      res_data_q, res_data_d;
    logic                                       issued_q,   issued_d;

`ifdef CHESS_HOST_TIMEOUT_EN
    localparam int PW = $clog2(POLL_LIMIT + 1);
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          error_q,    error_d;
`else
    logic [31:0]   w_unused_poll_limit;
    assign w_unused_poll_limit = POLL_LIMIT;
`endif

    // Access engine request side
    logic                  w_req;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_ready;
    logic                  w_ack;
    logic [DATA_WIDTH-1:0] w_rdata;

    avmm_single_access #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_access (
        .clk              (clk),
        .reset            (reset),
        .req              (w_req),
        .we               (w_we),
        .addr             (w_addr),
        .wdata            (w_wdata),
        .ready            (w_ready),
        .ack              (w_ack),
        .rdata            (w_rdata),
        .master_address   (master_address),
        .master_read      (master_read),
        .master_write     (master_write),
        .master_writedata (master_writedata),
        .master_readdata  (master_readdata)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            idx_q      <= '0;
            k_q        <= '0;
            res_data_q <= '0;
            issued_q   <= 1'b0;
`ifdef CHESS_HOST_TIMEOUT_EN
            poll_cnt_q <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            res_data_q <= res_data_d;
            issued_q   <= issued_d;
`ifdef CHESS_HOST_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
            error_q    <= error_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Each bus state issues one access and advances
    // only on the engine's ack.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        idx_d      = idx_q;
        k_d        = k_q;
        res_data_d = res_data_q;
        issued_d   = issued_q;
`ifdef CHESS_HOST_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        error_d    = error_q;
`endif

        // issued marks that the current state's access is in flight, so the
        // request is not repeated when the engine returns to idle.
        if (w_req && w_ready) begin
            issued_d = 1'b1;
        end
        if (w_ack) begin
            issued_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rows_d  = cmd_board;
                    idx_d   = '0;
                    state_d = ST_CLEAR;
`ifdef CHESS_HOST_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            ST_CLEAR: begin
                if (w_ack) begin
                    if (idx_q == 4'(CLEAR_WORDS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_ack) begin
                    if (idx_q == 4'(BOARD_ROWS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_CTRL;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_CTRL: begin
                if (w_ack) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_ack) begin
                    state_d = ST_POLL;
`ifdef CHESS_HOST_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end
            end
            ST_POLL: begin
                if (w_ack) begin
                    if (w_rdata[DONE_BIT]) begin
                        k_d     = '0;
                        state_d = ST_FETCH;
                    end else begin
`ifdef CHESS_HOST_TIMEOUT_EN
                        // A done bit on the final allowed poll still wins
                        if (poll_cnt_q == PW'(POLL_LIMIT - 1)) begin
                            error_d = 1'b1;
                            state_d = ST_FINISH;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 1'b1;
                        end
`endif
                    end
                end
            end
            ST_FETCH: begin
                if (w_ack) begin
                    res_data_d = w_rdata;
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // No access is requested here, so a stalled consumer also
                // stalls the bus.
                if (res_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                if (w_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / access request decode
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready         = (state_q == ST_IDLE);
        busy              = (state_q != ST_IDLE);
        res_valid         = (state_q == ST_EMIT);
        res_last          = (state_q == ST_EMIT) && (k_q == K_LAST);
        res_data          = res_data_q;
        master_byteenable = '1;
`ifdef CHESS_HOST_TIMEOUT_EN
        error             = error_q;
`else
        error             = 1'b0;
`endif

        w_req   = 1'b0;
        w_we    = 1'b1;
        w_addr  = ADDR_WIDTH'(CTRL_ADDR);
        w_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                w_req  = !issued_q;
                w_addr = ADDR_WIDTH'(idx_q);
            end
            ST_LOAD: begin
                w_req   = !issued_q;
                w_addr  = ADDR_WIDTH'(BOARD_BASE) + ADDR_WIDTH'(idx_q);
                w_wdata = rows_q[idx_q[2:0]];
            end
            ST_CTRL: begin
                w_req   = !issued_q;
                w_wdata = CTRL_MODE;
            end
            ST_START: begin
                w_req   = !issued_q;
                w_wdata = START_WORD;
            end
            ST_POLL: begin
                w_req = !issued_q;
                w_we  = 1'b0;
            end
            ST_FETCH: begin
                w_req  = !issued_q;
                w_we   = 1'b0;
                w_addr = ADDR_WIDTH'(RESULT_BASE) + ADDR_WIDTH'(k_q);
            end
            ST_FINISH: begin
                w_req   = !issued_q;
                w_wdata = CTRL_MODE;
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
